// File: rtl/plugin_initiator.sv
// Core-side initiator for the plugin start/busy/done handshake: issues one operation,
// waits for done (with optional timeout) and hands the result to writeback.
module plugin_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned RD_WIDTH       = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_op_a_i,
    input  logic [31:0]         req_op_b_i,
    input  logic [RD_WIDTH-1:0] req_rd_i,
    output logic                stall_o,
    output logic                plugin_start_o,
    output logic [31:0]         plugin_operand_a_o,
    output logic [31:0]         plugin_operand_b_o,
    input  logic                plugin_busy_i,
    input  logic                plugin_done_i,
    input  logic [31:0]         plugin_result_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_result_o,
    output logic [RD_WIDTH-1:0] rsp_rd_o,
    output logic                rsp_error_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StDrain} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [31:0]         op_a_q, op_a_d, op_b_q, op_b_d;
    logic [31:0]         result_q, result_d;
    logic [RD_WIDTH-1:0] rd_q, rd_d;
    logic                error_q, error_d;
    logic                timeout_hit;

    // Counter saturates; the >= compare keeps DRAIN exitable even after saturation.
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            rd_q     <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        rd_d     = rd_q;
        error_d  = error_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i && !flush_i) begin
                    op_a_d  = req_op_a_i;
                    op_b_d  = req_op_b_i;
                    rd_d    = req_rd_i;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (!plugin_busy_i) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (plugin_done_i) begin
                    if (flush_i) begin
                        state_d = StIdle;
                    end else begin
                        result_d = plugin_result_i;
                        error_d  = 1'b0;
                        state_d  = StResp;
                    end
                end else if (timeout_hit) begin
                    if (flush_i) begin
                        state_d = StIdle;
                    end else begin
                        result_d = '0;
                        error_d  = 1'b1;
                        state_d  = StResp;
                    end
                end else if (flush_i) begin
                    // Plugin is still running: wait for it to finish before reissuing.
                    state_d = StDrain;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StResp: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (plugin_done_i || timeout_hit) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o    = 1'b0;
        plugin_start_o = 1'b0;
        rsp_valid_o    = 1'b0;
        stall_o        = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_o = !flush_i;
                stall_o     = req_valid_i;
            end
            StIssue: begin
                plugin_start_o = !plugin_busy_i && !flush_i;
                stall_o        = 1'b1;
            end
            StWait:  stall_o = 1'b1;
            StResp: begin
                rsp_valid_o = 1'b1;
                stall_o     = !rsp_ready_i;
            end
            StDrain: stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    assign plugin_operand_a_o = op_a_q;
    assign plugin_operand_b_o = op_b_q;
    assign rsp_result_o       = result_q;
    assign rsp_rd_o           = rd_q;
    assign rsp_error_o        = error_q;

endmodule

// File: tb/tb_plugin_initiator.sv
// Self-checking bench for plugin_initiator with a 4-cycle adder plugin model and a
// response scoreboard.
module tb_plugin_initiator;

    localparam int unsigned TO  = 8;
    localparam int unsigned RDW = 5;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            flush_i = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [31:0]     req_op_a_i = '0;
    logic [31:0]     req_op_b_i = '0;
    logic [RDW-1:0]  req_rd_i = '0;
    logic            stall_o;
    logic            plugin_start_o;
    logic [31:0]     plugin_operand_a_o;
    logic [31:0]     plugin_operand_b_o;
    logic            plugin_busy_i;
    logic            plugin_done_i;
    logic [31:0]     plugin_result_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic [31:0]     rsp_result_o;
    logic [RDW-1:0]  rsp_rd_o;
    logic            rsp_error_o;

    plugin_initiator #(.TIMEOUT_CYCLES(TO), .RD_WIDTH(RDW)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .flush_i            (flush_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_op_a_i         (req_op_a_i),
        .req_op_b_i         (req_op_b_i),
        .req_rd_i           (req_rd_i),
        .stall_o            (stall_o),
        .plugin_start_o     (plugin_start_o),
        .plugin_operand_a_o (plugin_operand_a_o),
        .plugin_operand_b_o (plugin_operand_b_o),
        .plugin_busy_i      (plugin_busy_i),
        .plugin_done_i      (plugin_done_i),
        .plugin_result_i    (plugin_result_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_result_o       (rsp_result_o),
        .rsp_rd_o           (rsp_rd_o),
        .rsp_error_o        (rsp_error_o)
    );

    always #5 clk = ~clk;

    // Adder plugin: done pulse four cycles after the start cycle.
    logic [2:0]  pcnt = '0;
    logic [31:0] pres = '0;
    logic        force_busy = 1'b0;
    logic        mute = 1'b0;
    int          n_start = 0;

    always @(posedge clk) begin
        if (plugin_start_o) begin
            pcnt    <= 3'd4;
            pres    <= plugin_operand_a_o + plugin_operand_b_o;
            n_start <= n_start + 1;
        end else if (pcnt != 0) begin
            pcnt <= pcnt - 3'd1;
        end
    end

    assign plugin_done_i   = !mute && (pcnt == 3'd1);
    assign plugin_busy_i   = force_busy || (pcnt != 0);
    assign plugin_result_i = pres;

    typedef struct {
        logic [31:0]    a;
        logic [31:0]    b;
        logic [RDW-1:0] rd;
        logic [31:0]    res;
        int             hold;
    } vec_t;

    typedef struct {
        logic [31:0]    res;
        logic [RDW-1:0] rd;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (rsp_valid_o && rsp_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got result %0h rd %0d, expected none",
                         rsp_result_o, rsp_rd_o);
            end else begin
                e = sb.pop_front();
                chk("rsp_result", rsp_result_o, e.res);
                chk("rsp_rd", 32'(rsp_rd_o), 32'(e.rd));
                chk("rsp_error", 32'(rsp_error_o), 32'(e.err));
            end
        end
    endtask

    task automatic smp();
        @(negedge clk);
        mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Entered at negedge of a cycle with no response yet; finishes after the handshake.
    task automatic wait_rsp(input int hold);
        int n;
        n = 0;
        rsp_ready_i = (hold == 0);
        while (!rsp_valid_o && n < 40) begin
            adv();
            smp();
            n++;
        end
        if (!rsp_valid_o) begin
            chk("rsp_timeout", 32'(rsp_valid_o), 32'd1);
        end else if (hold > 0) begin
            for (int i = 1; i < hold; i++) begin
                adv();
                smp();
            end
            adv();
            rsp_ready_i = 1'b1;
            smp();
        end
        adv();
        rsp_ready_i = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [RDW-1:0] rd,
                          input logic [31:0] res, input logic err, input int hold);
        int n;
        n = 0;
        req_valid_i = 1'b1;
        req_op_a_i  = a;
        req_op_b_i  = b;
        req_rd_i    = rd;
        smp();
        while (!req_ready_o && n < 20) begin
            adv();
            smp();
            n++;
        end
        if (!req_ready_o) begin
            chk("req_accept_timeout", 32'(req_ready_o), 32'd1);
        end else begin
            sb.push_back('{res: res, rd: rd, err: err});
        end
        adv();
        req_valid_i = 1'b0;
        smp();
        wait_rsp(hold);
    endtask

    vec_t vecs[6];
    int   n;
    int   s0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{a: 32'h0000_0005, b: 32'h0000_0007, rd: 5'd3,  res: 32'h0000_000C, hold: 0};
        vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0002, rd: 5'd1,  res: 32'h0000_0001, hold: 0};
        vecs[2] = '{a: 32'h0000_0000, b: 32'h0000_0000, rd: 5'd0,  res: 32'h0000_0000, hold: 1};
        vecs[3] = '{a: 32'h8000_0000, b: 32'h8000_0000, rd: 5'd31, res: 32'h0000_0000, hold: 2};
        vecs[4] = '{a: 32'h1234_5678, b: 32'h1111_1111, rd: 5'd7,  res: 32'h2345_6789, hold: 0};
        vecs[5] = '{a: 32'hDEAD_BEEF, b: 32'h0000_0001, rd: 5'd18, res: 32'hDEAD_BEF0, hold: 3};

        // Reset state, including combinational IDLE outputs.
        req_valid_i = 1'b1;
        #12;
        chk("rst_stall_valid", 32'(stall_o), 32'd1);
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_start", 32'(plugin_start_o), 32'd0);
        req_valid_i = 1'b0;
        #1;
        chk("rst_stall_idle", 32'(stall_o), 32'd0);
        adv();
        reset_n = 1'b1;
        adv();

        // Latency: accept c0, start c1, rsp_valid c6.
        s0 = n_start;
        req_valid_i = 1'b1;
        req_op_a_i  = 32'h5;
        req_op_b_i  = 32'h7;
        req_rd_i    = 5'd3;
        rsp_ready_i = 1'b1;
        smp();
        chk("lat_accept", 32'(req_ready_o), 32'd1);
        sb.push_back('{res: 32'hC, rd: 5'd3, err: 1'b0});
        adv();
        req_valid_i = 1'b0;
        smp();
        chk("lat_start_c1", 32'(plugin_start_o), 32'd1);
        chk("lat_opa", plugin_operand_a_o, 32'h5);
        chk("lat_opb", plugin_operand_b_o, 32'h7);
        n = 1;
        while (!rsp_valid_o && n < 30) begin
            adv();
            smp();
            n++;
        end
        chk("lat_rsp_cycle", 32'(n), 32'd6);
        adv();
        rsp_ready_i = 1'b0;
        chk("lat_one_start", 32'(n_start - s0), 32'd1);

        // Table-driven operations through the scoreboard.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, 1'b0, vecs[i].hold);
        end

        // Backpressure: response held while a new request waits.
        req_valid_i = 1'b1;
        req_op_a_i  = 32'h10;
        req_op_b_i  = 32'h20;
        req_rd_i    = 5'd9;
        smp();
        sb.push_back('{res: 32'h30, rd: 5'd9, err: 1'b0});
        adv();
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        smp();
        n = 0;
        while (!rsp_valid_o && n < 30) begin
            adv();
            smp();
            n++;
        end
        req_valid_i = 1'b1;
        req_op_a_i  = 32'h1;
        req_op_b_i  = 32'h2;
        req_rd_i    = 5'd4;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                adv();
                smp();
            end
            chk("bp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_result", rsp_result_o, 32'h30);
            chk("bp_rd", 32'(rsp_rd_o), 32'd9);
            chk("bp_stall", 32'(stall_o), 32'd1);
            chk("bp_req_ready", 32'(req_ready_o), 32'd0);
        end
        adv();
        rsp_ready_i = 1'b1;
        smp();
        chk("bp_hs_req_ready", 32'(req_ready_o), 32'd0);
        chk("bp_hs_stall", 32'(stall_o), 32'd0);
        adv();
        rsp_ready_i = 1'b0;
        smp();
        chk("bp_idle_accept", 32'(req_ready_o), 32'd1);
        sb.push_back('{res: 32'h3, rd: 5'd4, err: 1'b0});
        adv();
        req_valid_i = 1'b0;
        smp();
        wait_rsp(0);

        // Timeout: plugin never signals done; response after 8 WAIT cycles.
        mute        = 1'b1;
        req_valid_i = 1'b1;
        req_op_a_i  = 32'h55;
        req_op_b_i  = 32'h66;
        req_rd_i    = 5'd12;
        rsp_ready_i = 1'b1;
        smp();
        sb.push_back('{res: 32'h0, rd: 5'd12, err: 1'b1});
        adv();
        req_valid_i = 1'b0;
        smp();
        n = 1;
        while (!rsp_valid_o && n < 40) begin
            adv();
            smp();
            n++;
        end
        chk("to_rsp_cycle", 32'(n), 32'd10);
        adv();
        rsp_ready_i = 1'b0;
        mute        = 1'b0;

        // Flush in WAIT: drain until done, no response.
        req_valid_i = 1'b1;
        req_op_a_i  = 32'h3;
        req_op_b_i  = 32'h4;
        req_rd_i    = 5'd2;
        smp();
        adv();
        req_valid_i = 1'b0;
        smp();
        chk("fl_start", 32'(plugin_start_o), 32'd1);
        adv();
        smp();
        adv();
        flush_i = 1'b1;
        smp();
        chk("fl_c3_req_ready", 32'(req_ready_o), 32'd0);
        adv();
        flush_i = 1'b0;
        smp();
        chk("fl_c4_req_ready", 32'(req_ready_o), 32'd0);
        chk("fl_c4_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("fl_c4_stall", 32'(stall_o), 32'd1);
        adv();
        smp();
        chk("fl_c5_req_ready", 32'(req_ready_o), 32'd0);
        adv();
        smp();
        chk("fl_c6_req_ready", 32'(req_ready_o), 32'd1);
        chk("fl_c6_rsp_valid", 32'(rsp_valid_o), 32'd0);
        adv();
        run_op(32'h40, 32'h2, 5'd6, 32'h42, 1'b0, 0);

        // Busy on entry to ISSUE withholds start; then reset mid-WAIT.
        req_valid_i = 1'b1;
        req_op_a_i  = 32'h100;
        req_op_b_i  = 32'h23;
        req_rd_i    = 5'd17;
        smp();
        adv();
        req_valid_i = 1'b0;
        force_busy  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            smp();
            chk("busy_no_start", 32'(plugin_start_o), 32'd0);
            chk("busy_opa_stable", plugin_operand_a_o, 32'h100);
            adv();
        end
        force_busy = 1'b0;
        smp();
        chk("busy_start_on_fall", 32'(plugin_start_o), 32'd1);
        adv();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_start", 32'(plugin_start_o), 32'd0);
        chk("mid_rst_opa", plugin_operand_a_o, 32'h0);
        chk("mid_rst_opb", plugin_operand_b_o, 32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_result", rsp_result_o, 32'h0);
        chk("mid_rst_rd", 32'(rsp_rd_o), 32'd0);
        chk("mid_rst_error", 32'(rsp_error_o), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) adv();
        run_op(32'h7, 32'h8, 5'd21, 32'hF, 1'b0, 1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
